// File: rtl/mult_div_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_div_unit_if                                                     |
// | Pipeline-side bundle of the HI/LO multiply/divide unit.              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface mult_div_unit_if;
    logic        req;
    logic [3:0]  mdOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] rdata;

    modport master (
        output req, mdOp, A, B,
        input  start, busy, HI, LO, rdata
    );

    modport slave (
        input  req, mdOp, A, B,
        output start, busy, HI, LO, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_div_unit                                                        |
// | Multi-cycle MIPS-style mult/div with HI/LO registers and moves.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  md
);

    localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_busy;
    logic                 r_div0;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          r_tmp_hi;
    logic [31:0]          r_tmp_lo;

    logic                 w_is_mult;
    logic                 w_is_div;
    logic                 w_accept;
    logic                 w_b_zero;
    logic                 w_div_ovf;
    logic signed [63:0]   w_prod_s;
    logic [63:0]          w_prod_u;
    logic signed [31:0]   w_quot_s;
    logic signed [31:0]   w_rem_s;
    logic [31:0]          w_quot_u;
    logic [31:0]          w_rem_u;
    logic [31:0]          w_res_hi;
    logic [31:0]          w_res_lo;

    assign w_is_mult = (md.mdOp == 4'd1) || (md.mdOp == 4'd2);
    assign w_is_div  = (md.mdOp == 4'd3) || (md.mdOp == 4'd4);
    assign w_accept  = (w_is_mult || w_is_div) && !r_busy && !md.req;
    assign w_b_zero  = (md.B == 32'd0);
    // INT_MIN / -1 overflows; pin it to the wrapped quotient with zero remainder
    assign w_div_ovf = (md.A == 32'h8000_0000) && (md.B == 32'hFFFF_FFFF);

    assign w_prod_s = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
    assign w_prod_u = {32'd0, md.A} * {32'd0, md.B};
    assign w_quot_s = (w_b_zero || w_div_ovf) ? $signed(md.A) : $signed(md.A) / $signed(md.B);
    assign w_rem_s  = (w_b_zero || w_div_ovf) ? 32'sd0 : $signed(md.A) % $signed(md.B);
    assign w_quot_u = w_b_zero ? 32'd0 : md.A / md.B;
    assign w_rem_u  = w_b_zero ? 32'd0 : md.A % md.B;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (md.mdOp)
            4'd1: {w_res_hi, w_res_lo} = w_prod_s;
            4'd2: {w_res_hi, w_res_lo} = w_prod_u;
            4'd3: begin w_res_hi = w_rem_s; w_res_lo = w_quot_s; end
            4'd4: begin w_res_hi = w_rem_u; w_res_lo = w_quot_u; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_tmp_hi <= 32'd0;
            r_tmp_lo <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tmp_hi <= w_res_hi;
                        r_tmp_lo <= w_res_lo;
                        r_div0   <= w_is_div && w_b_zero;
                        r_busy   <= 1'b1;
                        r_count  <= w_is_mult ? c_CNT_W'(MULT_CYCLES) : c_CNT_W'(DIV_CYCLES);
                        r_state  <= w_is_mult ? MULT_RUN : DIV_RUN;
                    end else if (!md.req && md.mdOp == 4'd7) begin
                        r_hi <= md.A;
                    end else if (!md.req && md.mdOp == 4'd8) begin
                        r_lo <= md.A;
                    end
                end
                MULT_RUN, DIV_RUN: begin
                    // req is deliberately ignored here: a committed op always retires
                    r_count <= r_count - 1'b1;
                    if (r_count == c_CNT_W'(1)) begin
                        if (!r_div0) begin
                            r_hi <= r_tmp_hi;
                            r_lo <= r_tmp_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign md.start = w_accept;
    assign md.busy  = r_busy;
    assign md.HI    = r_hi;
    assign md.LO    = r_lo;
    assign md.rdata = (md.mdOp == 4'd5) ? r_hi :
                      (md.mdOp == 4'd6) ? r_lo : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mult_div_unit                                                     |
// | Directed + randomized scoreboard bench for mult_div_unit.            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_mult_div_unit;

    localparam int c_MC = 5;
    localparam int c_DC = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] sb_q[$];

    mult_div_unit_if md ();

    mult_div_unit #(
        .MULT_CYCLES (c_MC),
        .DIV_CYCLES  (c_DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        logic signed [63:0] sa, sb;
        logic [31:0] ua, ub, uq, ur;
        case (op)
            4'd1: begin
                sa = {{32{a[31]}}, a};
                sb = {{32{b[31]}}, b};
                return sa * sb;
            end
            4'd2: return {32'd0, a} * {32'd0, b};
            4'd3: begin
                if (b == 32'd0) return {hi, lo};
                ua = a[31] ? -a : a;
                ub = b[31] ? -b : b;
                uq = ua / ub;
                ur = ua % ub;
                return {(a[31] ? -ur : ur), ((a[31] ^ b[31]) ? -uq : uq)};
            end
            4'd4: begin
                if (b == 32'd0) return {hi, lo};
                return {a % b, a / b};
            end
            default: return {hi, lo};
        endcase
    endfunction

    // Called at posedge+1; leaves the bench at posedge+1 after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_start);
        md.mdOp = op;
        md.A    = a;
        md.B    = b;
        #1;
        check("start", {31'd0, md.start}, {31'd0, exp_start});
        if (exp_start) sb_q.push_back(model(op, a, b, m_hi, m_lo));
        @(posedge clk);
        #1;
        md.mdOp = 4'd0;
    endtask

    task automatic wait_done(input string tag, input int exp_cycles, input logic disturb);
        int cnt;
        int guard;
        logic [63:0] exp;
        cnt   = 0;
        guard = 0;
        while (md.busy === 1'b1 && guard < 200) begin
            cnt++;
            if (disturb) begin
                md.req  = cnt[0];
                md.mdOp = (cnt == exp_cycles) ? 4'd7 : 4'd1;
                md.A    = 32'hDEAD_0000 + 32'(cnt);
                md.B    = 32'd3;
                #1;
                check("start_while_busy", {31'd0, md.start}, 32'd0);
                @(posedge clk);
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
            guard++;
        end
        md.req  = 1'b0;
        md.mdOp = 4'd0;
        check({tag, "_busy_cycles"}, 32'(cnt), 32'(exp_cycles));
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            exp  = sb_q.pop_front();
            m_hi = exp[63:32];
            m_lo = exp[31:0];
            check({tag, "_HI"}, md.HI, m_hi);
            check({tag, "_LO"}, md.LO, m_lo);
        end
    endtask

    task automatic move(input logic [3:0] op, input logic [31:0] a, input logic r);
        md.mdOp = op;
        md.A    = a;
        md.req  = r;
        @(posedge clk);
        #1;
        md.mdOp = 4'd0;
        md.req  = 1'b0;
        if (!r && op == 4'd7) m_hi = a;
        if (!r && op == 4'd8) m_lo = a;
        check("move_HI", md.HI, m_hi);
        check("move_LO", md.LO, m_lo);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        checks  = 0;
        errors  = 0;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
        reset   = 1'b1;
        md.req  = 1'b0;
        md.mdOp = 4'd0;
        md.A    = 32'd0;
        md.B    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, md.busy}, 32'd0);
        check("rst_HI", md.HI, 32'd0);
        check("rst_LO", md.LO, 32'd0);
        check("rst_rdata", md.rdata, 32'd0);
        reset = 1'b0;

        issue(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
        wait_done("mult", c_MC, 1'b0);
        check("mult_HI_const", md.HI, 32'hFFFF_FFFF);
        check("mult_LO_const", md.LO, 32'hFFFF_FFFE);

        issue(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
        wait_done("multu", c_MC, 1'b0);
        check("multu_HI_const", md.HI, 32'h0000_0001);
        check("multu_LO_const", md.LO, 32'hFFFF_FFFE);

        issue(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        wait_done("div", c_DC, 1'b0);
        check("div_HI_const", md.HI, 32'hFFFF_FFFF);
        check("div_LO_const", md.LO, 32'hFFFF_FFFD);

        issue(4'd4, 32'h1234_0000, 32'h0000_0000, 1'b1);
        wait_done("divu_by0", c_DC, 1'b0);

        move(4'd7, 32'h1234_5678, 1'b0);
        md.mdOp = 4'd5;
        #1 check("mfhi", md.rdata, 32'h1234_5678);
        md.mdOp = 4'd6;
        #1 check("mflo", md.rdata, m_lo);
        md.mdOp = 4'd9;
        #1 check("rdata_none", md.rdata, 32'd0);
        md.mdOp = 4'd0;
        @(posedge clk);
        #1;
        move(4'd8, 32'hCAFE_F00D, 1'b1);
        move(4'd8, 32'h0BAD_BEEF, 1'b0);

        md.req = 1'b1;
        issue(4'd1, 32'd7, 32'd9, 1'b0);
        md.req = 1'b0;
        check("req_block_busy", {31'd0, md.busy}, 32'd0);
        check("req_block_HI", md.HI, m_hi);
        check("req_block_LO", md.LO, m_lo);

        // req, a second mult and a completion-cycle mthi all land while busy
        issue(4'd3, 32'd100, 32'hFFFF_FFF9, 1'b1);
        wait_done("div_req", c_DC, 1'b1);

        for (int i = 0; i < 4; i++) begin
            rop = 4'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = (i == 2) ? 32'd0 : 32'($urandom_range(1, 50000));
            if ($urandom_range(0, 1) == 1) rb = -rb;
            issue(rop, ra, rb, 1'b1);
            wait_done("rand", (rop <= 4'd2) ? c_MC : c_DC, 1'b0);
        end

        issue(4'd1, 32'd3, 32'd5, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, md.busy}, 32'd0);
        check("async_rst_HI", md.HI, 32'd0);
        check("async_rst_LO", md.LO, 32'd0);
        sb_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        #1 reset = 1'b0;
        #1;
        check("post_rst_HI", md.HI, 32'd0);
        check("post_rst_LO", md.LO, 32'd0);
        issue(4'd2, 32'h0001_0000, 32'h0001_0000, 1'b1);
        wait_done("first_after_rst", c_MC, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 clk  input  1  single system clock, rising-edge active.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  exception/interrupt flush; the EX-stage instruction is cancelled this cycle.
REQ-006 mdOp  input  4  op from ID/EX register; 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 treated as none.
REQ-007 A  input  32  forwarded rs operand.
REQ-008 B  input  32  forwarded rt operand.
REQ-009 start  output  1  combinational; high when a mult/div is accepted this cycle.
REQ-010 busy  output  1  registered; high while a mult/div is in progress.
REQ-011 HI  output  32  registered HI architectural register.
REQ-012 LO  output  32  registered LO architectural register.
REQ-013 rdata  output  32  combinational read result for mfhi/mflo.

Function
REQ-014 The unit SHALL be a three-state machine: IDLE, MULT_RUN, DIV_RUN.
REQ-015 Accept condition: mdOp in {1..4}, busy=0, req=0; start = that condition.
REQ-016 On accept, the unit SHALL latch the full 64-bit result into internal temp registers: mult signed A*B, multu unsigned A*B, hi=product[63:32], lo=product[31:0]; div/divu lo=quotient, hi=remainder, signed ops truncate toward zero with remainder sign following A.
REQ-017 On accept, the unit SHALL enter MULT_RUN or DIV_RUN, load a counter with MULT_CYCLES or DIV_CYCLES, and drive busy=1 from the next cycle.
REQ-018 In a RUN state, the counter SHALL decrement each cycle; on the edge where it reaches 0, the unit SHALL write the temp registers into HI/LO, set busy=0, and return to IDLE.
REQ-019 Latency: busy SHALL stay high for exactly N cycles (N=MULT_CYCLES or DIV_CYCLES), and HI/LO SHALL update on the edge that deasserts busy.
REQ-020 Divide by zero (B=0 with div/divu): busy timing SHALL be unchanged, and HI/LO SHALL keep their prior values at completion.
REQ-021 mthi/mtlo SHALL write A into HI/LO respectively on the next edge, only when busy=0 and req=0.
REQ-022 rdata SHALL equal HI for mfhi, LO for mflo, and 0 otherwise; it SHALL read the current register values regardless of busy (the hazard unit stalls md instructions while busy|start).
REQ-023 req SHALL block new accepts and mthi/mtlo writes in the same cycle.
REQ-024 req SHALL NOT abort an operation already in a RUN state; the committed op SHALL complete normally.
REQ-025 mdOp 1..4 while busy=1 SHALL be ignored (no restart, no counter change).
REQ-026 An mthi/mtlo presented on the completion cycle SHALL be ignored, since busy=1 at that edge.

Reset
REQ-027 On reset assertion, the unit SHALL immediately set state=IDLE, counter=0, busy=0, HI=0, LO=0, and clear the temp registers, independent of clk.
REQ-028 Reset mid-operation SHALL discard the in-flight result, and HI/LO SHALL remain 0 after release.
REQ-029 After reset deassertion, the first accept SHALL be possible on the first rising edge.

Verification
REQ-030 Reset, then mult A=0xFFFFFFFF B=0x00000002 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-031 multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-032 div A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; then divu with B=0 -> HI/LO unchanged after 10 cycles.
REQ-033 mthi A=0x12345678, then mfhi -> rdata=0x12345678; mtlo with req=1 -> LO unchanged.
REQ-034 mult with req=1 on the issue cycle -> start=0, busy stays 0, HI/LO unchanged; req asserted during a running div -> op completes with the correct result.
REQ-035 Assert reset asynchronously at cycle 3 of a mult -> busy=0 and HI=LO=0 immediately, before the next clk edge; a second mult issued while busy -> ignored.
